rfsoc_cfg_serializer: RTL and testbench
=======================================

# rfsoc_cfg_serializer

Drives the 8-bit configuration GPIO bus that loads the per-channel serial configuration shift registers (mask, channel select, cycle count, mux set). It takes one parallel command at a time and emits the data serially on the shared data line, clocking it with the selected serial clock line. It sits between a command source (AXI-lite register bank or sequencer) and the GPIO bus feeding the channel logic.

## Interface
- DATA_W, 256, width of cmd_data; maximum bits per command (cycle-count register length)
- HALF_PERIOD, 4, system clocks per serial clock half-period; must be ≥1
- clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  block can accept a command
- cmd_target  in  3  serial clock to drive: 1 mask, 2 select, 3 cycle count, 4 mux set
- cmd_len  in  9  number of bits to shift, legal 1..DATA_W
- cmd_data  in  DATA_W  payload, bits [cmd_len-1:0] used
- abort  in  1  cancel the transfer in progress
- gpio_out  out  8  GPIO bus: bit0 sdata, bit1 mask clk, bit2 select clk, bit3 cycle-count clk, bit4 mux-set clk, bits 7:5 always 0
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse, transfer completed
- err  out  1  one-cycle pulse, command rejected

## Operation
- One clock domain, one synchronous active-low reset; all outputs registered.
- Reset values: gpio_out=0, cmd_ready=0, busy=0, done=0, err=0; state IDLE. cmd_ready rises the first cycle after rst_n is released.
- States: IDLE, LOW, HIGH.
- IDLE: cmd_ready=1. Accept on cmd_valid&cmd_ready. Latch target, len, data. cmd_ready drops the next cycle.
- Illegal command (target 0 or >4, len 0, len >DATA_W): next cycle err=1, cmd_ready=1, gpio_out stays 0, no clock toggles.
- Legal command: enter LOW. Load the bit index with len-1. Bits go MSB-first (data[len-1] first, data[0] last), so bit0 ends in receiver position 0.
- LOW, HALF_PERIOD cycles: gpio_out[0]=current bit, selected clock=0.
- HIGH, HALF_PERIOD cycles: sdata unchanged, selected clock=1. The receiver samples on this rising edge.
- End of HIGH:
  - If bits remain: decrement the index and go to LOW. sdata changes in the same cycle the clock falls.
  - Otherwise go to IDLE. In that cycle gpio_out=0, done=1, cmd_ready=1.
- Non-selected clock bits and bits 7:5 are always 0. busy=1 in LOW/HIGH.
- abort in LOW/HIGH: next cycle gpio_out=0, IDLE, cmd_ready=1, no done, no err. abort in IDLE is ignored. abort with cmd_valid in IDLE: the command is accepted.
- rst_n low mid-transfer: next edge applies reset values, with no done or err.
- Counters: bit index 9 bits; phase counter $clog2(HALF_PERIOD+1) bits, counting 0..HALF_PERIOD-1 and wrapping.

## Timing
- Acceptance at edge 0. For bit k (k=0 first sent), with H=HALF_PERIOD:
  - LOW occupies cycles 2Hk+1..2Hk+H.
  - HIGH occupies cycles 2Hk+H+1..2H(k+1).
- done and cmd_ready=1 at cycle 2H·len+1. Next acceptance is possible at that edge; back-to-back commands have one idle-bus cycle between them.
- Rejected command: err at cycle 1. Next acceptance possible at cycle 1.
- Setup of sdata to the rising clock edge = H cycles; hold after the edge = H cycles.

## Test plan
- H=4, target 4, len 1, data 1, accepted cycle 0 -> gpio_out=8'h01 cycles 1-4, 8'h11 cycles 5-8, 8'h00 with done=1 and cmd_ready=1 at cycle 9.
- Target 2, len 16, data 16'h0004 -> exactly 16 rising edges on gpio_out[2], only 14th edge sees sdata=1, other GPIO bits 0, done at cycle 129.
- Target 3, len 256, random data -> bench shift register clocked by gpio_out[3] equals data; done at cycle 2049; busy high cycles 1-2048.
- Target 0 len 5; target 4 len 0; target 1 len 257 -> each: err=1 at cycle 1, gpio_out never nonzero, cmd_ready=1 at cycle 1.
- Target 1, len 16, abort during HIGH of bit 3 -> gpio_out=0 next cycle, no done/err, cmd_ready=1; a following target-4 len-1 command completes normally.
- rst_n low for one cycle during a LOW phase -> next cycle all outputs 0 and cmd_ready=0; cmd_ready=1 one cycle after release; no done pulse observed.

Source files
------------

// File: rtl/rfsoc_cfg_serializer_if.sv
// Command handshake and GPIO output bundle for the configuration serializer.
interface rfsoc_cfg_serializer_if #(
  parameter int unsigned DATA_W = 256
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_target;
  logic [8:0]        cmd_len;
  logic [DATA_W-1:0] cmd_data;
  logic              abort;
  logic [7:0]        gpio_out;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output cmd_valid, cmd_target, cmd_len, cmd_data, abort,
    input  cmd_ready, gpio_out, busy, done, err
  );

  modport slave (
    input  cmd_valid, cmd_target, cmd_len, cmd_data, abort,
    output cmd_ready, gpio_out, busy, done, err
  );
endinterface

// File: rtl/rfsoc_cfg_serializer.sv
// Shifts one parallel command MSB-first onto the GPIO data line, clocking it
// with the selected per-channel serial clock line.
module rfsoc_cfg_serializer #(
  parameter int unsigned DATA_W      = 256,
  parameter int unsigned HALF_PERIOD = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  rfsoc_cfg_serializer_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(DATA_W);
  localparam int unsigned PH_W  = $clog2(HALF_PERIOD + 1);
  localparam int unsigned LEN_W = 9;

  typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH} state_t;

  state_t            r_state;
  logic [7:0]        r_gpio;
  logic [7:0]        r_clk_sel;
  logic              r_ready;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic [PH_W-1:0]   r_phase;
  logic [LEN_W-1:0]  r_bit_idx;
  logic [DATA_W-1:0] r_data;

  logic              w_accept;
  logic              w_cmd_legal;
  logic              w_first_bit;
  logic              w_next_bit;
  logic              w_phase_end;
  logic [7:0]        w_clk_sel;

  // Command legality and the first bit to present on sdata.
  assign w_accept    = bus.cmd_valid && r_ready;
  assign w_cmd_legal = (bus.cmd_target >= 3'd1) && (bus.cmd_target <= 3'd4) &&
                       (bus.cmd_len != '0) && (bus.cmd_len <= LEN_W'(DATA_W));
  assign w_first_bit = bus.cmd_data[IDX_W'(bus.cmd_len - LEN_W'(1))];
  assign w_next_bit  = r_data[IDX_W'(r_bit_idx - LEN_W'(1))];
  assign w_phase_end = (r_phase == PH_W'(HALF_PERIOD - 1));
  assign w_clk_sel   = 8'(8'd1 << bus.cmd_target);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_gpio    <= '0;
      r_clk_sel <= '0;
      r_ready   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_phase   <= '0;
      r_bit_idx <= '0;
      r_data    <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_gpio  <= '0;
          if (w_accept) begin
            if (w_cmd_legal) begin
              r_state   <= S_LOW;
              r_ready   <= 1'b0;
              r_busy    <= 1'b1;
              r_data    <= bus.cmd_data;
              r_bit_idx <= bus.cmd_len - LEN_W'(1);
              r_clk_sel <= w_clk_sel;
              r_phase   <= '0;
              r_gpio    <= {7'd0, w_first_bit};
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_LOW: begin
          if (bus.abort) begin
            r_state <= S_IDLE;
            r_gpio  <= '0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end else if (w_phase_end) begin
            r_state <= S_HIGH;
            r_phase <= '0;
            r_gpio  <= r_gpio | r_clk_sel;
          end else begin
            r_phase <= r_phase + PH_W'(1);
          end
        end
        S_HIGH: begin
          // Falling clock and the next data bit change on the same edge.
          if (bus.abort) begin
            r_state <= S_IDLE;
            r_gpio  <= '0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end else if (w_phase_end) begin
            r_phase <= '0;
            if (r_bit_idx != '0) begin
              r_state   <= S_LOW;
              r_bit_idx <= r_bit_idx - LEN_W'(1);
              r_gpio    <= {7'd0, w_next_bit};
            end else begin
              r_state <= S_IDLE;
              r_gpio  <= '0;
              r_done  <= 1'b1;
              r_ready <= 1'b1;
              r_busy  <= 1'b0;
            end
          end else begin
            r_phase <= r_phase + PH_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_gpio  <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready = r_ready;
  assign bus.gpio_out  = r_gpio;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_rfsoc_cfg_serializer.sv
// Directed bench: commands push expectations to a scoreboard that is checked
// when done/err pulses, alongside cycle-exact checks of the bus waveform.
module tb_rfsoc_cfg_serializer;
  localparam int unsigned DATA_W = 256;
  localparam int unsigned H      = 4;

  typedef struct {
    bit                is_err;
    int unsigned       edge_exp;
    int unsigned       len;
    logic [DATA_W-1:0] data;
    logic [2:0]        tgt;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rfsoc_cfg_serializer_if #(.DATA_W(DATA_W)) bus ();

  rfsoc_cfg_serializer #(.DATA_W(DATA_W), .HALF_PERIOD(H)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t              sb[$];
  int                n_checks = 0;
  int                n_errs   = 0;
  int unsigned       edge_n   = 0;
  logic [3:0]        prev_clk = '0;
  logic [DATA_W-1:0] sh       = '0;
  int                edges_line[8];
  int                busy_cyc = 0;
  int                gpio_nz  = 0;
  int                bad_hi   = 0;

  task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_tally();
    sh       = '0;
    busy_cyc = 0;
    gpio_nz  = 0;
    for (int i = 0; i < 8; i++) edges_line[i] = 0;
  endtask

  task automatic score();
    exp_t              e;
    logic [DATA_W-1:0] m;
    int                tot;
    if (sb.size() == 0) begin
      check("unexpected_pulse", DATA_W'({bus.done, bus.err}), '0);
    end else begin
      e   = sb.pop_front();
      tot = 0;
      for (int i = 0; i < 8; i++) tot += edges_line[i];
      check("pulse_kind", DATA_W'({bus.done, bus.err}), DATA_W'(e.is_err ? 2'b01 : 2'b10));
      check("pulse_edge", DATA_W'(edge_n), DATA_W'(e.edge_exp));
      check("ready_at_pulse", DATA_W'(bus.cmd_ready), DATA_W'(1));
      check("gpio_at_pulse", DATA_W'(bus.gpio_out), '0);
      check("edges_total", DATA_W'(tot), DATA_W'(e.is_err ? 0 : e.len));
      check("busy_cycles", DATA_W'(busy_cyc), DATA_W'(e.is_err ? 0 : 2 * H * e.len));
      if (e.is_err) begin
        check("err_gpio_nonzero_cycles", DATA_W'(gpio_nz), '0);
      end else begin
        m = (e.len >= DATA_W) ? '1 : ((DATA_W'(1) << e.len) - DATA_W'(1));
        check("edges_on_target", DATA_W'(edges_line[e.tgt]), DATA_W'(e.len));
        check("shifted_data", sh & m, e.data & m);
      end
    end
    clr_tally();
  endtask

  // Advance one clock; sample the bus on the falling edge.
  task automatic tick();
    logic [3:0] rise;
    @(posedge clk);
    edge_n++;
    @(negedge clk);
    rise     = bus.gpio_out[4:1] & ~prev_clk;
    prev_clk = bus.gpio_out[4:1];
    for (int i = 0; i < 4; i++) begin
      if (rise[i]) begin
        edges_line[i+1]++;
        sh = {sh[DATA_W-2:0], bus.gpio_out[0]};
      end
    end
    if (bus.gpio_out[7:5] != 3'd0) bad_hi++;
    if ($countones(bus.gpio_out[4:1]) > 1) bad_hi++;
    if (bus.busy === 1'b1) busy_cyc++;
    if (bus.gpio_out != 8'd0) gpio_nz++;
    if (bus.done === 1'b1 || bus.err === 1'b1) score();
  endtask

  task automatic send(input logic [2:0] tgt, input logic [8:0] len,
                      input logic [DATA_W-1:0] data);
    exp_t e;
    int   guard = 0;
    while (bus.cmd_ready !== 1'b1 && guard < 5000) begin
      tick();
      guard++;
    end
    check("ready_before_send", DATA_W'(bus.cmd_ready), DATA_W'(1));
    bus.cmd_valid  = 1'b1;
    bus.cmd_target = tgt;
    bus.cmd_len    = len;
    bus.cmd_data   = data;
    e.is_err   = !(tgt >= 3'd1 && tgt <= 3'd4 && len >= 9'd1 && len <= 9'(DATA_W));
    e.edge_exp = edge_n + 1 + (e.is_err ? 0 : 2 * H * 32'(len));
    e.len      = 32'(len);
    e.data     = data;
    e.tgt      = tgt;
    sb.push_back(e);
    clr_tally();
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_timeout", DATA_W'(sb.size()), '0);
    sb.delete();
  endtask

  task automatic check_idle_outputs(input string tag, input logic ready_exp);
    check({tag, "_gpio"},  DATA_W'(bus.gpio_out),  '0);
    check({tag, "_ready"}, DATA_W'(bus.cmd_ready), DATA_W'(ready_exp));
    check({tag, "_busy"},  DATA_W'(bus.busy),      '0);
    check({tag, "_done"},  DATA_W'(bus.done),      '0);
    check({tag, "_err"},   DATA_W'(bus.err),       '0);
  endtask

  initial begin
    logic [DATA_W-1:0] rnd;
    logic [7:0]        g_exp;
    bus.cmd_valid  = 1'b0;
    bus.cmd_target = '0;
    bus.cmd_len    = '0;
    bus.cmd_data   = '0;
    bus.abort      = 1'b0;
    clr_tally();

    // Reset state, then ready one cycle after release.
    repeat (3) tick();
    check_idle_outputs("reset", 1'b0);
    rst_n = 1'b1;
    tick();
    check("ready_after_release", DATA_W'(bus.cmd_ready), DATA_W'(1));

    // Single bit on the mux-set clock, cycle-exact waveform.
    send(3'd4, 9'd1, DATA_W'(1));
    for (int c = 1; c <= 9; c++) begin
      if (c > 1) tick();
      g_exp = (c <= 4) ? 8'h01 : (c <= 8) ? 8'h11 : 8'h00;
      check($sformatf("t1_gpio_c%0d", c), DATA_W'(bus.gpio_out), DATA_W'(g_exp));
      check($sformatf("t1_busy_c%0d", c), DATA_W'(bus.busy), DATA_W'(c <= 8));
    end
    check("t1_done_c9", DATA_W'(bus.done), DATA_W'(1));
    check("t1_ready_c9", DATA_W'(bus.cmd_ready), DATA_W'(1));
    tick();
    check("t1_done_one_cycle", DATA_W'(bus.done), '0);
    drain(10);

    // 16 bits on the select clock, then back-to-back full-length transfer.
    send(3'd2, 9'd16, DATA_W'(16'h0004));
    drain(3000);
    for (int i = 0; i < DATA_W / 32; i++) rnd[i*32 +: 32] = $urandom;
    send(3'd3, 9'd256, rnd);
    drain(3000);

    // Illegal commands, each rejected with err at cycle 1.
    send(3'd0, 9'd5, DATA_W'(32'hFFFF_FFFF));
    send(3'd4, 9'd0, DATA_W'(32'hFFFF_FFFF));
    send(3'd1, 9'd257, '1);
    send(3'd5, 9'd8, '1);
    drain(10);

    // Abort during HIGH of bit 3 (cycles 29..32).
    send(3'd1, 9'd16, DATA_W'(16'hBEEF));
    repeat (29) tick();
    check("abort_in_high", DATA_W'(bus.gpio_out[1]), DATA_W'(1));
    check("abort_edges_so_far", DATA_W'(edges_line[1]), DATA_W'(4));
    void'(sb.pop_back());
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check_idle_outputs("abort", 1'b1);
    repeat (3) tick();
    send(3'd4, 9'd1, DATA_W'(1));
    drain(20);

    // Abort while idle is ignored and a simultaneous command is accepted.
    bus.abort = 1'b1;
    send(3'd1, 9'd3, DATA_W'(3'b101));
    bus.abort = 1'b0;
    drain(100);

    // Reset pulse during LOW of bit 0.
    send(3'd1, 9'd8, DATA_W'(8'hA5));
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    void'(sb.pop_back());
    check_idle_outputs("midreset", 1'b0);
    tick();
    check("midreset_ready_after_release", DATA_W'(bus.cmd_ready), DATA_W'(1));
    repeat (80) tick();

    check("gpio_high_bits_and_onehot", DATA_W'(bad_hi), '0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
